// File: rtl/phase_sequencer.sv
// phase_sequencer: IDLE -> P1 -> P2 -> P3 -> P34 -> P4 -> P5 phase generator for the SIMPLE core.
// Optional SINGLE_STEP_EN: a rising edge on step in IDLE (run=0) launches exactly one instruction.
module phase_sequencer #(
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 255,
  parameter int STALL_CW    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic             stall,
  input  logic             step,
  output logic             p1,
  output logic             p2,
  output logic             p3,
  output logic             p4,
  output logic             p5,
  output logic             p3to4,
  output logic             idle,
  output logic [CNT_W-1:0] instr_count,
  output logic             stall_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_P1, S_P2, S_P3, S_P34, S_P4, S_P5
  } state_t;

  localparam logic [STALL_CW-1:0] LIMIT = STALL_CW'(STALL_LIMIT);

  state_t              state_q, state_d;
  logic [STALL_CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    instr_count_d;
  logic                stall_err_d;
  logic                start;

`ifdef SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= step;
  end

  // run wins; otherwise only a fresh 0->1 on step launches an instruction.
  assign start = run | (step & ~step_q);
`else
  logic unused_step;
  assign unused_step = step;
  assign start       = run;
`endif

  always_comb begin
    state_d       = state_q;
    stall_cnt_d   = stall_cnt_q;
    instr_count_d = instr_count;
    stall_err_d   = stall_err;
    case (state_q)
      S_IDLE: if (start) state_d = S_P1;
      S_P1:   state_d = S_P2;
      S_P2:   state_d = S_P3;
      S_P3:   state_d = S_P34;
      S_P34, S_P4: begin
        // A stall is honoured until the counter reaches the limit; then the phase is forced on.
        if (stall && stall_cnt_q != LIMIT) begin
          stall_cnt_d = stall_cnt_q + STALL_CW'(1);
        end else begin
          if (stall) stall_err_d = 1'b1;
          stall_cnt_d = '0;
          state_d     = (state_q == S_P34) ? S_P4 : S_P5;
        end
      end
      S_P5: begin
        instr_count_d = instr_count + CNT_W'(1);
        state_d       = (halt_req || !run) ? S_IDLE : S_P1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      stall_cnt_q <= '0;
      instr_count <= '0;
      stall_err   <= 1'b0;
      idle        <= 1'b1;
      p1          <= 1'b0;
      p2          <= 1'b0;
      p3          <= 1'b0;
      p3to4       <= 1'b0;
      p4          <= 1'b0;
      p5          <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      instr_count <= instr_count_d;
      stall_err   <= stall_err_d;
      idle        <= (state_d == S_IDLE);
      p1          <= (state_d == S_P1);
      p2          <= (state_d == S_P2);
      p3          <= (state_d == S_P3);
      p3to4       <= (state_d == S_P34);
      p4          <= (state_d == S_P4);
      p5          <= (state_d == S_P5);
    end
  end

endmodule
